out_uart_tx: RTL and testbench

Serial console sink for the CPU's output port. Sits directly downstream of the output register. Each time the control word asserts the output-load bit on an enabled clock, the block captures the bus value into a small FIFO. It transmits each captured word over an 8N1 UART line as uppercase ASCII hex, MSB nibble first, followed by a line feed. This lets a board build show program results on a terminal without the simulator hooks.

---
 rtl/out_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_out_uart_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// Serial console sink: buffers words loaded into the CPU output register and
// prints each one as uppercase ASCII hex plus a line feed over an 8N1 UART line.
module out_uart_tx #(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_load,
    input  logic [DATA_WIDTH-1:0]         i_load_data,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int NCHAR  = DATA_WIDTH / 4 + 1;
    localparam int IDX_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CIDX_W = $clog2(NCHAR);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, count;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head;

    state_t                state, state_d;
    logic [BAUD_W-1:0]     baud, baud_d;
    logic                  baud_done;
    logic [2:0]            bit_idx, bit_idx_d;
    logic [CIDX_W-1:0]     char_idx, char_idx_d;
    logic [DATA_WIDTH-1:0] word, word_d, next_word;
    logic [7:0]            char_q, char_d;
    logic                  tx_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PTR_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[IDX_W-1:0]];
    // A pop frees a slot this same edge, so a load into a full FIFO still fits.
    assign push  = i_load & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (i_load & full & ~pop)
                o_overflow <= 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which entries are valid, so clearing the array would only add reset fanout.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[IDX_W-1:0]] <= i_load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            word     <= '0;
            char_q   <= '0;
            o_tx     <= 1'b1;
        end else begin
            state    <= state_d;
            baud     <= baud_d;
            bit_idx  <= bit_idx_d;
            char_idx <= char_idx_d;
            word     <= word_d;
            char_q   <= char_d;
            o_tx     <= tx_d;
        end
    end

    assign baud_done = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign next_word = word << 4;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        baud_d     = baud + 1'b1;
        bit_idx_d  = bit_idx;
        char_idx_d = char_idx;
        word_d     = word;
        char_d     = char_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    state_d    = START;
                    word_d     = head;
                    char_idx_d = '0;
                    char_d     = hex_char(head[DATA_WIDTH-1 -: 4]);
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7)
                        state_d = STOP;
                    else
                        bit_idx_d = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (char_idx == CIDX_W'(NCHAR - 1)) begin
                        state_d = IDLE;
                    end else begin
                        // Chain straight into the next character with no idle gap.
                        state_d    = START;
                        char_idx_d = char_idx + 1'b1;
                        word_d     = next_word;
                        char_d     = (char_idx_d == CIDX_W'(NCHAR - 1)) ? 8'h0A
                                   : hex_char(next_word[DATA_WIDTH-1 -: 4]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state and then registered.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    assign o_busy  = (state != IDLE) | ~empty;
    assign o_count = count;

endmodule

// File: tb/tb_out_uart_tx.sv
// Self-checking bench for out_uart_tx: directed vectors, corner-case sequences and
// randomized loads, with a UART line decoder and a timing-level reference model.
module tb_out_uart_tx;

    localparam int CPB     = 4;
    localparam int DEPTH   = 4;
    localparam int NCHAR16 = 5;
    localparam int FRAME16 = NCHAR16 * 10 * CPB;

    logic        clk, rst;
    logic        load16, load8;
    logic [15:0] data16;
    logic [7:0]  data8;
    logic        tx16, busy16, ov16, tx8, busy8, ov8;
    logic [2:0]  count16, count8;

    out_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut16 (
        .clk(clk), .rst(rst), .i_load(load16), .i_load_data(data16),
        .o_tx(tx16), .o_busy(busy16), .o_overflow(ov16), .o_count(count16));

    out_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .i_load(load8), .i_load_data(data8),
        .o_tx(tx8), .o_busy(busy8), .o_overflow(ov8), .o_count(count8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words wait in a queue; a popped word occupies the line for
    // FRAME16 cycles, and a pop can only happen once the previous word is done.
    logic [15:0] m_q[$];
    int          m_rem = 0;
    logic        m_ov  = 1'b0;
    logic [7:0]  exp_q[$];

    function automatic void push_word_chars(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) begin
            int nib = int'((w >> (4 * i)) & 16'hF);
            exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10));
        end
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void model_step(input logic ld, input logic [15:0] d);
        logic do_pop, accept;
        do_pop = (m_rem == 0) && (m_q.size() != 0);
        accept = ld && ((m_q.size() < DEPTH) || do_pop);
        if (ld && !accept)
            m_ov = 1'b1;
        if (do_pop) begin
            void'(m_q.pop_front());
            m_rem = FRAME16;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (accept) begin
            m_q.push_back(d);
            push_word_chars(d);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_rem = 0;
        m_ov  = 1'b0;
        exp_q.delete();
    endfunction

    // UART decoder on a selectable line; samples mid-bit on falling clock edges.
    logic       mon_sel = 1'b0;
    logic       mon_tx;
    int         rst_epoch = 0;
    int         lf_count = 0;
    logic [7:0] rx_log[$];
    assign mon_tx = mon_sel ? tx8 : tx16;

    initial begin : monitor
        int         ep;
        logic [7:0] b;
        logic       s_start, s_stop;
        forever begin
            @(negedge clk);
            if (!rst && mon_tx == 1'b0) begin
                ep = rst_epoch;
                repeat (CPB / 2) @(negedge clk);
                s_start = mon_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = mon_tx;
                end
                repeat (CPB) @(negedge clk);
                s_stop = mon_tx;
                if (ep == rst_epoch) begin
                    check("rx_start_bit", s_start, 1'b0);
                    check("rx_stop_bit", s_stop, 1'b1);
                    rx_log.push_back(b);
                    if (b == 8'h0A)
                        lf_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got %0h, expected no byte", b);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1);
    end

    task automatic cycle(input logic ld, input logic [15:0] d);
        load16 = ld;
        data16 = d;
        @(posedge clk);
        model_step(ld, d);
        @(negedge clk);
        load16 = 1'b0;
        check("model_count", count16, m_q.size());
        check("model_busy", busy16, (m_rem != 0) || (m_q.size() != 0));
        check("model_overflow", ov16, m_ov);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((busy16 || m_rem != 0 || m_q.size() != 0) && n < budget) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        repeat (2) cycle(1'b0, 16'h0);
        check({name, "_drain_busy"}, busy16, 1'b0);
        check({name, "_drain_bytes_left"}, exp_q.size(), 0);
    endtask

    task automatic check_rx(input string name, input logic [79:0] bytes, input int n);
        check({name, "_rx_len"}, rx_log.size(), n);
        for (int i = 0; i < n && i < rx_log.size(); i++)
            check($sformatf("%s_rx%0d", name, i), rx_log[i], bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic do_reset(input string name);
        #1 rst = 1'b1;
        rst_epoch++;
        model_reset();
        #1;
        check({name, "_rst_tx"}, tx16, 1'b1);
        check({name, "_rst_count"}, count16, 0);
        check({name, "_rst_busy"}, busy16, 1'b0);
        check({name, "_rst_overflow"}, ov16, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ld;
        logic [15:0] d;
        int          exp_count;
        logic        exp_busy;
        logic        exp_ov;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int bc, n, lf_before;
        vecs[0] = '{1'b1, 16'h1111, 1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h2222, 1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 16'h3333, 2, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h4444, 3, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h5555, 4, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h6666, 4, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h7777, 4, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 16'h0000, 4, 1'b1, 1'b1};

        load16 = 1'b0; data16 = '0; load8 = 1'b0; data8 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_tx", tx16, 1'b1);
        check("reset_busy", busy16, 1'b0);
        check("reset_overflow", ov16, 1'b0);
        check("reset_count", count16, 0);
        check("reset_tx8", tx8, 1'b1);
        check("reset_count8", count8, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle(1'b0, 16'h0);

        // Single word: character stream, busy length, first falling edge.
        rx_log.delete();
        bc = 0;
        cycle(1'b1, 16'h1A2F);
        if (busy16) bc++;
        check("t1_tx_after_load", tx16, 1'b1);
        cycle(1'b0, 16'h0);
        if (busy16) bc++;
        check("t1_tx_fall", tx16, 1'b0);
        n = 0;
        while (busy16 && n < 1000) begin
            cycle(1'b0, 16'h0);
            if (busy16) bc++;
            n++;
        end
        check("t1_busy_cycles", bc, 1 + FRAME16);
        drain("t1", 100);
        check_rx("t1", 80'h31_41_32_46_0A, 5);

        // Back-to-back words: pop spacing is one word plus one idle cycle.
        rx_log.delete();
        cycle(1'b1, 16'h0000);
        check("t2_count_first", count16, 1);
        cycle(1'b1, 16'hFFFF);
        check("t2_count_load_and_pop", count16, 1);
        n = 0;
        while (count16 != 0 && n < 400) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        check("t2_pop_gap", n, FRAME16 + 1);
        check("t2_count_second_pop", count16, 0);
        drain("t2", 400);
        check_rx("t2", 80'h30_30_30_30_0A_46_46_46_46_0A, 10);

        // Overflow burst from the vector table.
        lf_before = lf_count;
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].ld, vecs[i].d);
            check($sformatf("vec%0d_count", i), count16, vecs[i].exp_count);
            check($sformatf("vec%0d_busy", i), busy16, vecs[i].exp_busy);
            check($sformatf("vec%0d_overflow", i), ov16, vecs[i].exp_ov);
        end
        drain("t3", 3000);
        check("t3_words_sent", lf_count - lf_before, DEPTH + 1);

        // Full FIFO with a load landing on the idle pop edge.
        do_reset("t4");
        cycle(1'b1, 16'hA0A0);
        cycle(1'b0, 16'h0);
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 16'(16'hB0B0 + i));
        check("t4_count_full", count16, DEPTH);
        n = 0;
        while (m_rem != 0 && n < 400) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        cycle(1'b1, 16'hC5C5);
        check("t4_count_after_pop_load", count16, DEPTH);
        check("t4_no_overflow", ov16, 1'b0);
        drain("t4", 2000);

        // Reset in the middle of character 2, then a clean frame.
        cycle(1'b1, 16'hBEEF);
        repeat (95) cycle(1'b0, 16'h0);
        do_reset("t5");
        repeat (45) cycle(1'b0, 16'h0);
        rx_log.delete();
        cycle(1'b1, 16'h5A3C);
        drain("t5", 400);
        check_rx("t5", 80'h35_41_33_43_0A, 5);

        // 8-bit instance: three characters, 30 bit times.
        mon_sel = 1'b1;
        rx_log.delete();
        exp_q.push_back(8'h39);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h0A);
        load8 = 1'b1;
        data8 = 8'h9C;
        @(posedge clk);
        @(negedge clk);
        load8 = 1'b0;
        check("t6_count", count8, 1);
        check("t6_tx_after_load", tx8, 1'b1);
        bc = busy8 ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        check("t6_tx_fall", tx8, 1'b0);
        if (busy8) bc++;
        n = 0;
        while (busy8 && n < 500) begin
            @(posedge clk);
            @(negedge clk);
            if (busy8) bc++;
            n++;
        end
        check("t6_busy_cycles", bc, 1 + 30 * CPB);
        check("t6_overflow", ov8, 1'b0);
        repeat (2) @(negedge clk);
        check_rx("t6", 80'h39_43_0A, 3);
        check("t6_bytes_left", exp_q.size(), 0);
        mon_sel = 1'b0;

        // Randomized loads at a light and a heavy rate.
        for (int i = 0; i < 3000; i++) begin
            logic ld;
            ld = (i < 1500) ? ($urandom_range(0, 999) < 4) : ($urandom_range(0, 99) < 3);
            cycle(ld, 16'($urandom));
        end
        drain("rand", 6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
